// File: rtl/rgb2gs_arbiter_if.sv
// ============================================================================
// Module      : rgb2gs_arbiter_if
// Description : Source handshakes, shared-converter link and result lanes of
//               the two-source rgb2gs arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface rgb2gs_arbiter_if;
    logic [23:0] s0_rgb;
    logic        s0_valid;
    logic        s0_ready;
    logic [23:0] s1_rgb;
    logic        s1_valid;
    logic        s1_ready;
    logic [23:0] conv_rgb;
    logic        conv_en;
    logic [7:0]  conv_gs;
    logic        conv_valid;
    logic [7:0]  m0_gs;
    logic        m0_valid;
    logic [7:0]  m1_gs;
    logic        m1_valid;

    // Arbiter side
    modport master (
        input  s0_rgb, s0_valid, s1_rgb, s1_valid, conv_gs, conv_valid,
        output s0_ready, s1_ready, conv_rgb, conv_en,
               m0_gs, m0_valid, m1_gs, m1_valid
    );

    // Sources, converter and result consumers
    modport slave (
        output s0_rgb, s0_valid, s1_rgb, s1_valid, conv_gs, conv_valid,
        input  s0_ready, s1_ready, conv_rgb, conv_en,
               m0_gs, m0_valid, m1_gs, m1_valid
    );
endinterface

`default_nettype wire

// File: rtl/rgb2gs_arbiter.sv
// ============================================================================
// Module      : rgb2gs_arbiter
// Description : Round-robin, burst-limited arbiter sharing one rgb2gs converter
//               between two pixel sources; tags results back to their lane.
//               Optional macro RGB2GS_ARB_STATS_EN adds grant statistics.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module rgb2gs_arbiter #(
    parameter int BURST_LEN = 4,
    parameter int CNT_W     = 16
) (
    input  wire logic             clk,
    input  wire logic             rst_n,
    rgb2gs_arbiter_if.master      bus
`ifdef RGB2GS_ARB_STATS_EN
    ,
    output      logic [CNT_W-1:0] grant_cnt0,
    output      logic [CNT_W-1:0] grant_cnt1
`endif
);

    localparam int               c_BW        = $clog2(BURST_LEN + 1);
    localparam logic [c_BW-1:0]  c_BURST_MAX = c_BW'(BURST_LEN);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_OWN0 = 2'd1,
        ST_OWN1 = 2'd2
    } state_t;

    state_t          r_state;
    logic [c_BW-1:0] r_burst_cnt;
    logic            r_last_served;
    logic            r_inflight;
    logic            r_tag;

    logic            w_pick0;
    logic            w_pick1;
    logic            w_grant0;
    logic            w_grant1;
    logic            w_conv_en;
    logic [c_BW-1:0] w_cnt_inc;

    always_comb begin
        w_pick0 = 1'b0;
        w_pick1 = 1'b0;
        case (r_state)
            ST_IDLE: begin
                // Tie goes to whichever source was not served last
                if (bus.s0_valid && bus.s1_valid) begin
                    w_pick0 = r_last_served;
                    w_pick1 = !r_last_served;
                end else begin
                    w_pick0 = bus.s0_valid;
                    w_pick1 = bus.s1_valid;
                end
            end
            ST_OWN0: begin
                if (bus.s0_valid && (!bus.s1_valid || r_burst_cnt < c_BURST_MAX))
                    w_pick0 = 1'b1;
                else if (bus.s1_valid)
                    w_pick1 = 1'b1;
            end
            ST_OWN1: begin
                if (bus.s1_valid && (!bus.s0_valid || r_burst_cnt < c_BURST_MAX))
                    w_pick1 = 1'b1;
                else if (bus.s0_valid)
                    w_pick0 = 1'b1;
            end
            default: begin
                w_pick0 = 1'b0;
                w_pick1 = 1'b0;
            end
        endcase
    end

    // Gating with rst_n keeps the handshake silent while reset is held
    assign w_grant0  = w_pick0 & rst_n;
    assign w_grant1  = w_pick1 & rst_n;
    assign w_conv_en = w_grant0 | w_grant1;

    // Saturates so a lone owner can stream indefinitely without wrapping
    assign w_cnt_inc = (r_burst_cnt == c_BURST_MAX) ? r_burst_cnt
                                                    : r_burst_cnt + c_BW'(1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= ST_IDLE;
            r_burst_cnt   <= '0;
            r_last_served <= 1'b1;
            r_inflight    <= 1'b0;
            r_tag         <= 1'b0;
        end else begin
            if (w_grant0) begin
                r_state       <= ST_OWN0;
                r_burst_cnt   <= (r_state == ST_OWN0) ? w_cnt_inc : c_BW'(1);
                r_last_served <= 1'b0;
            end else if (w_grant1) begin
                r_state       <= ST_OWN1;
                r_burst_cnt   <= (r_state == ST_OWN1) ? w_cnt_inc : c_BW'(1);
                r_last_served <= 1'b1;
            end else begin
                r_state       <= ST_IDLE;
                r_burst_cnt   <= '0;
            end

            r_inflight <= w_conv_en;
            if (w_conv_en)
                r_tag <= w_grant1;
        end
    end

    assign bus.s0_ready = w_grant0;
    assign bus.s1_ready = w_grant1;
    assign bus.conv_en  = w_conv_en;
    assign bus.conv_rgb = w_grant0 ? bus.s0_rgb :
                          w_grant1 ? bus.s1_rgb : 24'h0;

    // inflight masks stale converter strobes, e.g. right after reset release
    assign bus.m0_valid = bus.conv_valid & r_inflight & !r_tag;
    assign bus.m1_valid = bus.conv_valid & r_inflight &  r_tag;
    assign bus.m0_gs    = bus.conv_gs;
    assign bus.m1_gs    = bus.conv_gs;

`ifdef RGB2GS_ARB_STATS_EN
    logic [CNT_W-1:0] r_grant_cnt0;
    logic [CNT_W-1:0] r_grant_cnt1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_grant_cnt0 <= '0;
            r_grant_cnt1 <= '0;
        end else begin
            if (w_grant0 && (r_grant_cnt0 != {CNT_W{1'b1}}))
                r_grant_cnt0 <= r_grant_cnt0 + CNT_W'(1);
            if (w_grant1 && (r_grant_cnt1 != {CNT_W{1'b1}}))
                r_grant_cnt1 <= r_grant_cnt1 + CNT_W'(1);
        end
    end

    assign grant_cnt0 = r_grant_cnt0;
    assign grant_cnt1 = r_grant_cnt1;
`endif

endmodule

`default_nettype wire
